// File: rtl/prf_multiport.sv
// Physical register file with per-tag ready scoreboard, optional CDB bypass and optional registered issue read.
// Issue read latency is READ_LAT cycles (0 or 1) and retire read is combinational; there is no backpressure, every port is accepted every cycle.
module prf_multiport #(
    parameter int PRF_SIZE = 64,
    parameter int XLEN     = 32,
    parameter int N_RD     = 4,
    parameter int N_WR     = 2,
    parameter int N_DISP   = 2,
    parameter int N_RET    = 2,
    parameter int BYPASS   = 1,
    parameter int READ_LAT = 0,
    parameter int TAGW     = $clog2(PRF_SIZE)
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic [N_RD-1:0][TAGW-1:0]        rd_tag,
    output logic [N_RD-1:0][XLEN-1:0]        rd_data,
    output logic [N_RD-1:0]                  rd_ready,
    input  logic [N_WR-1:0]                  wb_en,
    input  logic [N_WR-1:0][TAGW-1:0]        wb_tag,
    input  logic [N_WR-1:0][XLEN-1:0]        wb_data,
    input  logic [N_DISP-1:0]                alloc_en,
    input  logic [N_DISP-1:0][TAGW-1:0]      alloc_tag,
    input  logic [N_RET-1:0]                 ret_en,
    input  logic [N_RET-1:0][TAGW-1:0]       ret_tag,
    input  logic [N_RET-1:0][TAGW-1:0]       ret_told,
    output logic [N_RET-1:0][XLEN-1:0]       ret_data,
    output logic                             err
);

    // Tag 0 and tags beyond PRF_SIZE never touch storage.
    function automatic logic tag_ok(input logic [TAGW-1:0] t);
        return (t != '0) && (int'(t) < PRF_SIZE);
    endfunction

    logic [XLEN-1:0]     data_q [PRF_SIZE];
    logic [XLEN-1:0]     data_d [PRF_SIZE];
    logic [PRF_SIZE-1:0] ready_q, ready_d;
    logic                err_q, err_d;

    // Apply frees first so writebacks override them, writebacks in ascending port
    // order so the highest port wins, and allocs last so they win on ready.
    always_comb begin
        logic alloc_hit;
        data_d    = data_q;
        ready_d   = ready_q;
        err_d     = err_q;
        alloc_hit = 1'b0;

        for (int j = 0; j < N_RET; j++) begin
            if (ret_en[j] && tag_ok(ret_told[j])) begin
                data_d[ret_told[j]] = '0;
            end
        end

        for (int i = 0; i < N_WR; i++) begin
            if (wb_en[i] && tag_ok(wb_tag[i])) begin
                data_d[wb_tag[i]]  = wb_data[i];
                ready_d[wb_tag[i]] = 1'b1;
                alloc_hit = 1'b0;
                for (int k = 0; k < N_DISP; k++) begin
                    if (alloc_en[k] && alloc_tag[k] == wb_tag[i]) begin
                        alloc_hit = 1'b1;
                    end
                end
                if (ready_q[wb_tag[i]] && !alloc_hit) begin
                    err_d = 1'b1;
                end
                for (int k = i + 1; k < N_WR; k++) begin
                    if (wb_en[k] && wb_tag[k] == wb_tag[i]) begin
                        err_d = 1'b1;
                    end
                end
            end
        end

        for (int k = 0; k < N_DISP; k++) begin
            if (alloc_en[k] && tag_ok(alloc_tag[k])) begin
                if (!ready_q[alloc_tag[k]]) begin
                    err_d = 1'b1;
                end
                ready_d[alloc_tag[k]] = 1'b0;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            for (int e = 0; e < PRF_SIZE; e++) begin
                data_q[e] <= '0;
            end
            ready_q <= '1;
            err_q   <= 1'b0;
        end else begin
            for (int e = 0; e < PRF_SIZE; e++) begin
                data_q[e] <= data_d[e];
            end
            ready_q <= ready_d;
            err_q   <= err_d;
        end
    end

    assign err = err_q;

    logic [N_RD-1:0][XLEN-1:0] rd_data_c;
    logic [N_RD-1:0]           rd_ready_c;

    // Descending scan so the lowest-indexed matching CDB port is forwarded.
    always_comb begin
        for (int p = 0; p < N_RD; p++) begin
            rd_data_c[p]  = '0;
            rd_ready_c[p] = 1'b1;
            if (tag_ok(rd_tag[p])) begin
                rd_data_c[p]  = data_q[rd_tag[p]];
                rd_ready_c[p] = ready_q[rd_tag[p]];
                if (BYPASS != 0) begin
                    for (int i = N_WR - 1; i >= 0; i--) begin
                        if (wb_en[i] && wb_tag[i] == rd_tag[p]) begin
                            rd_data_c[p]  = wb_data[i];
                            rd_ready_c[p] = 1'b1;
                        end
                    end
                end
            end
        end
    end

    generate
        if (READ_LAT == 0) begin : g_rd_comb
            assign rd_data  = rd_data_c;
            assign rd_ready = rd_ready_c;
        end else begin : g_rd_reg
            logic [N_RD-1:0][XLEN-1:0] rd_data_q;
            logic [N_RD-1:0]           rd_ready_q;
            always_ff @(posedge clock) begin
                if (!reset) begin
                    rd_data_q  <= '0;
                    rd_ready_q <= '1;
                end else begin
                    rd_data_q  <= rd_data_c;
                    rd_ready_q <= rd_ready_c;
                end
            end
            assign rd_data  = rd_data_q;
            assign rd_ready = rd_ready_q;
        end
    endgenerate

    always_comb begin
        for (int j = 0; j < N_RET; j++) begin
            ret_data[j] = '0;
            if (ret_en[j] && tag_ok(ret_tag[j])) begin
                ret_data[j] = data_q[ret_tag[j]];
            end
        end
    end

endmodule

// File: doc/prf_multiport.md
Name: prf_multiport

Overview:
- Parametrised physical register file with a per-tag ready (scoreboard) table. It replaces the fixed-width PRF in the out-of-order core.
- Serves N_RD issue read ports and N_RET retire read ports. Absorbs N_WR CDB writebacks, N_DISP dispatch allocations and N_RET retire frees per cycle.
- Adds over the previous generation: ready bits, optional CDB bypass, optional registered read stage, hardwired zero tag, and a sticky protocol-error flag.
- Sits between dispatch/issue, the FUs/CDB and retire.

Parameters:
- PRF_SIZE, 64, number of physical registers; TAGW = $clog2(PRF_SIZE).
- XLEN, 32, data width.
- N_RD, 4, issue read ports (2 per issue slot).
- N_WR, 2, CDB writeback ports.
- N_DISP, 2, dispatch allocation ports.
- N_RET, 2, retire ports.
- BYPASS, 1, 1 = same-cycle CDB forwarding on issue reads; 0 = none.
- READ_LAT, 0, issue-read latency in cycles: 0 = combinational, 1 = registered.

Ports:
- clock  in  1  single clock; all state updates on posedge.
- reset  in  1  synchronous, active-low reset, sampled on posedge clock.
- rd_tag  in  N_RD x TAGW  issue read tags.
- rd_data  out  N_RD x XLEN  issue read data.
- rd_ready  out  N_RD  issue read tag is ready (value valid).
- wb_en  in  N_WR  CDB complete.
- wb_tag  in  N_WR x TAGW  CDB destination tag.
- wb_data  in  N_WR x XLEN  CDB value.
- alloc_en  in  N_DISP  dispatch allocates a tag (clear ready).
- alloc_tag  in  N_DISP x TAGW  allocated tag.
- ret_en  in  N_RET  retire valid.
- ret_tag  in  N_RET x TAGW  retiring T (read).
- ret_told  in  N_RET x TAGW  retiring Told (freed).
- ret_data  out  N_RET x XLEN  value of ret_tag, combinational.
- err  out  1  sticky protocol-error flag.

Behaviour:
- State: data[PRF_SIZE][XLEN], ready[PRF_SIZE], err.
- Reset (reset==0 at posedge):
  - all data = 0, all ready = 1, err = 0;
  - with READ_LAT=1, registered rd_data = 0 and rd_ready = 1.
  - Reset overrides every same-cycle write/alloc/free. A mid-operation reset discards all in-flight updates.
- Tag 0 is hardwired:
  - reads return data 0, ready 1;
  - wb, alloc and free to tag 0 are ignored and do not set err.
- Writeback, per port i with wb_en[i]: data[wb_tag] <= wb_data, ready[wb_tag] <= 1.
- Alloc, per port with alloc_en: ready[alloc_tag] <= 0. Data is unchanged.
- Free, per port with ret_en: data[ret_told] <= 0. Ready is unchanged.
- Same-tag priority within one cycle:
  - For ready: alloc beats wb (ready=0; data still written).
  - For data: wb beats free.
  - Among wb ports, the highest index wins and err is set.
- err is set (sticky until reset) on any of:
  - two wb ports with the same nonzero tag in one cycle;
  - wb to a tag whose ready bit is 1 and that is not allocated the same cycle;
  - alloc of a tag whose ready bit is already 0.
- Issue read, READ_LAT=0:
  - if BYPASS=1 and some wb_en[i] has wb_tag[i]==rd_tag (nonzero), return wb_data of the lowest such i with rd_ready=1;
  - otherwise return data[rd_tag] and ready[rd_tag] from current state.
  - Outputs are driven for every port every cycle, with no latches.
- Issue read, READ_LAT=1:
  - the READ_LAT=0 result is registered; output appears the next cycle.
  - The registered value reflects state plus bypass at sample time, not later updates.
  - A same-cycle alloc of the read tag does not affect the registered value.
- Retire read: ret_data = data[ret_tag], with no bypass and no read-before-free hazard. Driven 0 when ret_en=0.
- All tag arithmetic is unsigned TAGW bits. Out-of-range tags (when PRF_SIZE is not a power of 2) read 0, are treated as ready, and their writes are ignored.

Test Plan:
- Reset, then read tags 0, 5, 63 -> data 0, ready 1, err=0. Hold reset=0 while wb_en=1 to tag 5 -> data[5] stays 0.
- Alloc tag 7 in cycle 1 -> rd_ready(7)=0 in cycle 2. wb tag 7 = 0xDEADBEEF in cycle 3:
  - BYPASS=1: read of 7 in cycle 3 returns 0xDEADBEEF, ready=1;
  - BYPASS=0: read returns the old value 0 and ready 0, then 0xDEADBEEF/1 in cycle 4.
- READ_LAT=1: issue rd_tag=9 in cycle N while wb 9=0x1234 -> rd_data=0x1234, rd_ready=1 in cycle N+1. A wb 9=0x5678 in N+1 is not seen until a read issued in N+1 (visible N+2).
- Same cycle: wb0 tag 12=0xA, wb1 tag 12=0xB -> data[12]=0xB, err=1 and stays 1 until reset. Both wb ports to tag 0 -> no err.
- Same cycle: alloc 20, wb 20=0x55, ret_told 20 -> ready[20]=0, data[20]=0x55. ret_en with ret_tag=20 next cycle -> ret_data=0x55.
- Alloc of tag 30 twice without an intervening wb -> err=1. Wb to a never-allocated ready tag 31 -> err=1.
